// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable width, divider, bit order, CPOL/CPHA,
// multiple active-low chip selects and full-duplex receive on IO1.
module spi_master_param #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int NUM_CS    = 2,
    parameter int CS_IDX_W  = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                CLK_16MHZ,
    input  logic                RST_N,
    input  logic                begin_send,
    input  logic                cpol,
    input  logic                cpha,
    input  logic [CS_IDX_W-1:0] cs_sel,
    input  logic [DATA_W-1:0]   tx_data,
    output logic [DATA_W-1:0]   rx_data,
    output logic                busy,
    output logic                done,
    output logic                output_clock,
    output logic [NUM_CS-1:0]   output_CS,
    output logic                IO0,
    input  logic                IO1
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [NUM_CS-1:0] cs_dec;
    logic              cpol_q;
    logic              cpha_q;
    logic              tick;
    logic              last_edge;
    logic              lead_edge;
    logic              start;
    logic              finish;
    logic              drive;
    logic              sample;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                   input logic b);
        return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    assign tick      = (div_cnt == DIV_LAST);
    assign last_edge = (edge_cnt == EDGE_LAST);
    // edge_cnt counts completed edges, so an even count means a leading edge is next
    assign lead_edge = ~edge_cnt[0];

    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_IDX_W'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK_16MHZ or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        drive      = 1'b0;
        sample     = 1'b0;
        unique case (state)
            IDLE: begin
                if (begin_send) begin
                    state_next = SETUP;
                    start      = 1'b1;
                end
            end
            SETUP: begin
                if (tick) state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sample = cpha_q ? ~lead_edge : lead_edge;
                    drive  = cpha_q ? lead_edge : (~lead_edge & ~last_edge);
                    if (last_edge) state_next = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_16MHZ or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt      <= '0;
            edge_cnt     <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            rx_data      <= '0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            output_clock <= 1'b0;
            output_CS    <= '1;
            IO0          <= 1'b0;
        end else begin
            done <= finish;

            if (start)               div_cnt <= '0;
            else if (state != IDLE)  div_cnt <= tick ? '0 : div_cnt + 1'b1;

            if (start)                      edge_cnt <= '0;
            else if (state == SHIFT && tick) edge_cnt <= edge_cnt + 1'b1;

            if (state == IDLE)               output_clock <= cpol;
            else if (state != SHIFT)         output_clock <= cpol_q;
            else if (tick)                   output_clock <= ~output_clock;

            if (start) begin
                busy      <= 1'b1;
                cpol_q    <= cpol;
                cpha_q    <= cpha;
                output_CS <= cs_dec;
                rx_sh     <= '0;
                // with cpha=0 the first bit must already sit on IO0 during SETUP
                tx_sh     <= cpha ? tx_data : shift_out(tx_data);
                IO0       <= cpha ? 1'b0 : first_bit(tx_data);
            end

            if (drive) begin
                IO0   <= first_bit(tx_sh);
                tx_sh <= shift_out(tx_sh);
            end

            if (sample) rx_sh <= shift_in(rx_sh, IO1);

            if (finish) begin
                busy      <= 1'b0;
                output_CS <= '1;
                IO0       <= 1'b0;
                rx_data   <= rx_sh;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Randomised bench for spi_master_param: a behavioural SPI slave/monitor
// checks MOSI, MISO capture, chip selects and busy/done timing.
module tb_spi_master_param;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance 0: 8-bit, divide-by-4, MSB first, two-bit cs_sel
    logic       rst0_n, begin_send0, cpol0, cpha0;
    logic [1:0] cs_sel0;
    logic [7:0] tx_data0, rx_data0;
    logic       busy0, done0, sclk0, io0_0, io1_0;
    logic [1:0] cs0;
    logic       loop0, miso0;

    assign io1_0 = loop0 ? io0_0 : miso0;

    spi_master_param #(
        .DATA_W(8), .CLK_DIV(4), .NUM_CS(2), .CS_IDX_W(2), .MSB_FIRST(1'b1)
    ) dut0 (
        .CLK_16MHZ(clk), .RST_N(rst0_n), .begin_send(begin_send0),
        .cpol(cpol0), .cpha(cpha0), .cs_sel(cs_sel0), .tx_data(tx_data0),
        .rx_data(rx_data0), .busy(busy0), .done(done0),
        .output_clock(sclk0), .output_CS(cs0), .IO0(io0_0), .IO1(io1_0)
    );

    // instance 1: 16-bit, divide-by-1, LSB first, loopback
    logic        rst1_n, begin_send1, cpol1, cpha1;
    logic [0:0]  cs_sel1;
    logic [15:0] tx_data1, rx_data1;
    logic        busy1, done1, sclk1, io0_1;
    logic [1:0]  cs1;

    spi_master_param #(
        .DATA_W(16), .CLK_DIV(1), .NUM_CS(2), .CS_IDX_W(1), .MSB_FIRST(1'b0)
    ) dut1 (
        .CLK_16MHZ(clk), .RST_N(rst1_n), .begin_send(begin_send1),
        .cpol(cpol1), .cpha(cpha1), .cs_sel(cs_sel1), .tx_data(tx_data1),
        .rx_data(rx_data1), .busy(busy1), .done(done1),
        .output_clock(sclk1), .output_CS(cs1), .IO0(io0_1), .IO1(io0_1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // behavioural slave for instance 0 (MSB-first words)
    logic       xfer0 = 1'b0;
    logic       s_cpol, s_cpha;
    logic [7:0] s_word, s_mosi;
    int         s_in, s_out, s_edges;

    always @(sclk0) begin
        if (xfer0) begin
            s_edges++;
            // sample on leading edge when cpha=0, on trailing edge when cpha=1
            if ((sclk0 != s_cpol) != s_cpha) begin
                if (s_in < 8) s_mosi[7 - s_in] = io0_0;
                s_in++;
            end else if (s_out < 8) begin
                miso0 = s_word[7 - s_out];
                s_out++;
            end
        end
    end

    // LSB-first MOSI monitor for instance 1 (mode 0: data valid at rising SCLK)
    logic [15:0] m1;
    int          n1;

    always @(posedge sclk1) begin
        if (n1 < 16) m1[n1] = io0_1;
        n1++;
    end

    task automatic run0(input logic [7:0] tx, input logic [7:0] slv,
                        input logic pol, input logic pha, input logic [1:0] sel,
                        input bit loop, input bit repulse);
        int busy_n, done_n, done_at;
        logic [1:0] exp_cs;
        exp_cs = (sel < 2) ? ~(2'b01 << sel) : 2'b11;
        @(negedge clk);
        cpol0 = pol; cpha0 = pha; cs_sel0 = sel; tx_data0 = tx; loop0 = loop;
        repeat (2) @(negedge clk);
        check("idle_sclk", 32'(sclk0), 32'(pol));
        s_word = slv; s_cpol = pol; s_cpha = pha;
        s_in = 0; s_edges = 0; s_mosi = '0;
        if (!pha) begin miso0 = slv[7]; s_out = 1; end
        else      begin miso0 = 1'b0;   s_out = 0; end
        xfer0 = 1'b1;
        begin_send0 = 1'b1;
        @(negedge clk);
        begin_send0 = 1'b0;
        check("busy_start", 32'(busy0), 32'd1);
        busy_n = 0; done_n = 0; done_at = -1;
        for (int t = 0; t < 82; t++) begin
            if (busy0) busy_n++;
            if (done0) begin
                done_n++;
                if (done_at < 0) done_at = t;
            end
            if (t == 20) check("cs_active", 32'(cs0), 32'(exp_cs));
            if (repulse && t == 30) begin tx_data0 = 8'h00; begin_send0 = 1'b1; end
            if (repulse && t == 31) begin_send0 = 1'b0;
            @(negedge clk);
        end
        xfer0 = 1'b0;
        check("busy_len", 32'(busy_n), 32'd72);
        check("done_cnt", 32'(done_n), 32'd1);
        check("done_lat", 32'(done_at), 32'd72);
        check("rx_data", 32'(rx_data0), loop ? 32'(tx) : 32'(slv));
        check("mosi_word", 32'(s_mosi), 32'(tx));
        check("sclk_edges", 32'(s_edges), 32'd16);
        check("cs_idle", 32'(cs0), 32'd3);
        check("io0_idle", 32'(io0_0), 32'd0);
    endtask

    task automatic run1(input logic [15:0] tx_a, input logic [15:0] tx_b);
        int busy_n, done_at;
        logic [15:0] exp_tx;
        @(negedge clk);
        cpol1 = 1'b0; cpha1 = 1'b0; cs_sel1 = 1'b0; tx_data1 = tx_a;
        repeat (2) @(negedge clk);
        n1 = 0; m1 = '0;
        exp_tx = tx_a;
        begin_send1 = 1'b1;
        @(negedge clk);
        begin_send1 = 1'b0;
        for (int xf = 0; xf < 2; xf++) begin
            check("b2b_busy_start", 32'(busy1), 32'd1);
            busy_n = 0; done_at = -1;
            for (int t = 0; t < 60; t++) begin
                if (busy1) busy_n++;
                if (done1) begin done_at = t; break; end
                @(negedge clk);
            end
            check("b2b_busy_len", 32'(busy_n), 32'd34);
            check("b2b_done_lat", 32'(done_at), 32'd34);
            check("b2b_cs_gap", 32'(cs1), 32'd3);
            check("b2b_rx", 32'(rx_data1), 32'(exp_tx));
            check("b2b_mosi_lsb", 32'(m1), 32'(exp_tx));
            if (xf == 0) begin
                tx_data1 = tx_b; exp_tx = tx_b;
                n1 = 0; m1 = '0;
                begin_send1 = 1'b1;
                @(negedge clk);
                begin_send1 = 1'b0;
            end
        end
    endtask

    initial begin
        int done_n;
        rst0_n = 1'b0; rst1_n = 1'b0;
        begin_send0 = 1'b0; cpol0 = 1'b1; cpha0 = 1'b0; cs_sel0 = '0;
        tx_data0 = '0; loop0 = 1'b1; miso0 = 1'b0;
        begin_send1 = 1'b0; cpol1 = 1'b1; cpha1 = 1'b0; cs_sel1 = '0;
        tx_data1 = '0; n1 = 0; m1 = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_cs", 32'(cs0), 32'd3);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_rx", 32'(rx_data0), 32'd0);
        check("rst_io0", 32'(io0_0), 32'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;

        run0(8'hA5, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        run0(8'hF0, 8'h3C, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        run0(8'h96, 8'h5A, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        run0(8'h3B, 8'hC4, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run0(8'($urandom), 8'($urandom), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 2'($urandom_range(3)),
                 bit'($urandom_range(1)), bit'($urandom_range(1)));
        end

        // asynchronous reset in the middle of a transfer
        @(negedge clk);
        cpol0 = 1'b0; cpha0 = 1'b0; cs_sel0 = 2'd0; tx_data0 = 8'h5A; loop0 = 1'b1;
        repeat (2) @(negedge clk);
        begin_send0 = 1'b1;
        @(negedge clk);
        begin_send0 = 1'b0;
        repeat (35) @(negedge clk);
        rst0_n = 1'b0;
        #1;
        check("arst_cs", 32'(cs0), 32'd3);
        check("arst_sclk", 32'(sclk0), 32'd0);
        check("arst_busy", 32'(busy0), 32'd0);
        check("arst_rx", 32'(rx_data0), 32'd0);
        done_n = 0;
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        for (int t = 0; t < 80; t++) begin
            if (done0) done_n++;
            @(negedge clk);
        end
        check("arst_no_done", 32'(done_n), 32'd0);
        check("arst_rx_hold", 32'(rx_data0), 32'd0);

        run1(16'h8001, 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
